fgen_spi_regbank: RTL
=====================

Name: fgen_spi_regbank

Overview:
- SPI slave register bank that writes the function generator's control inputs (mode, amplitude, offset, conf_1_reg..conf_3_reg) from the host MCU.
- Host writes into shadow registers; a commit copies all shadows to the live outputs in one clk cycle, so a waveform reconfiguration is never seen half-applied.
- Sits between the MCU SPI pins and the generator, in the 125 MHz clk domain.

Parameters:
- ID_VALUE, 32'h5A47_1021, constant returned by read of address 7.
- SYNC_STAGES, 2, synchroniser flops on spi_sck, spi_cs_n and spi_mosi (minimum 2).

Ports:
- clk  in  1  125 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- spi_sck  in  1  SPI clock, mode 0, asynchronous to clk, max clk/8
- spi_cs_n  in  1  SPI chip select, active low
- spi_mosi  in  1  SPI data in, MSB first
- spi_miso  out  1  SPI data out, MSB first
- mode  out  16  live mode register
- amplitude  out  16  live amplitude register
- offset  out  16  live offset register
- conf_1_reg  out  32  live config 1
- conf_2_reg  out  32  live config 2
- conf_3_reg  out  32  live config 3
- update_pulse  out  1  one-cycle strobe when the live registers load
- frame_err  out  1  one-cycle strobe on an aborted frame

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - All live and shadow registers are 0, so mode 0 gives zero output.
  - auto_commit = 0, spi_miso = 0, update_pulse = 0, frame_err = 0.
  - Bit counter is 0 and the FSM is in IDLE.
- SPI sampling:
  - spi_sck, spi_cs_n and spi_mosi pass through SYNC_STAGES flops.
  - Edges are detected on the synchronised spi_sck.
  - Data is sampled on the rising edge and spi_miso changes after the falling edge.
- Frame format: exactly 40 bits.
  - Command byte: bit7 = R(1)/W(0), bits6:0 = address.
  - Then 32 data bits.
- FSM:
  - IDLE -> CMD when synchronised cs_n falls.
  - CMD -> DATA after the 8th rising sck edge.
  - DATA -> DONE after the 40th rising sck edge.
  - DONE -> IDLE when cs_n rises.
  - Extra sck edges in DONE are ignored. There is no auto-increment.
- Address map:
  - 0 mode, 1 amplitude, 2 offset, 3 conf_1, 4 conf_2, 5 conf_3, 6 CTRL, 7 ID (read-only).
  - Addresses 8..127: writes ignored, reads return 0.
- Width rule:
  - 16-bit registers take data[15:0]; data[31:16] is discarded.
  - Reads of 16-bit registers return the value zero-extended to 32 bits.
- Write timing: the shadow register updates on the clk cycle after the 40th rising edge is detected.
- CTRL write:
  - data bit0 = 1 commits: on the next clk, all six live outputs load from the shadows and update_pulse = 1 for 1 cycle.
  - data bit1 is stored in auto_commit.
  - With auto_commit = 1, every write to addresses 0..5 also commits, on the cycle after the shadow write.
- CTRL read: returns {30'b0, auto_commit, 1'b0}.
- Read timing:
  - The addressed shadow or ID value is snapshotted on the cycle the 8th rising edge is detected.
  - spi_miso presents bit31 after the 8th falling edge, then one bit per falling edge.
  - spi_miso = 0 during the command byte, in IDLE and in DONE.
  - Reads never modify state.
- Abort: cs_n rising before 40 bits with bit counter > 0 means:
  - frame discarded, no register changes;
  - frame_err = 1 for 1 cycle;
  - FSM returns to IDLE.
- cs_n rising with 0 bits received: no error.
- Simultaneous events:
  - rst_n assertion wins over everything.
  - A commit while a new frame is shifting is allowed and does not disturb the shift.
  - A shadow write and a commit never share a cycle: the commit follows the write by 1 cycle.
- Reset mid-frame: the partial frame is lost and all outputs take their reset values immediately.

Optional Feature:
- Macro: FGEN_REGBANK_READBACK_EN.
- Defined: reads behave as above.
- Undefined:
  - No read path is built and spi_miso is tied to 0.
  - Read commands complete the frame with no effect; aborts still report frame_err.

Test Plan:
- Reset: release rst_n -> all outputs 0, update_pulse never asserted.
- Write-then-commit:
  - write addr 3 = 32'h0000_1388 -> conf_1_reg stays 0.
  - write addr 6 = 32'h1 -> conf_1_reg = 32'h1388 with one update_pulse, and the other live registers unchanged.
- Atomic multi-write:
  - write mode = 3, conf_1 = 100, conf_2 = 200, conf_3 = 8191 while mode = 0 live.
  - commit -> all four change on the same clk edge.
- Auto-commit: write addr 6 = 32'h2, then addr 0 = 32'hFFFF_0002 -> mode = 16'h0002 live one cycle after the shadow update.
- Abort: drop cs_n after 20 bits of a write to addr 4 -> frame_err pulse, shadow of conf_2 unchanged, next full frame accepted.
- Readback (macro defined):
  - read addr 7 -> MISO returns 32'h5A47_1021.
  - read addr 1 after writing 32'hABCD_1234 -> 32'h0000_1234.
  - read addr 9 -> 32'h0.

Source files
------------

// File: rtl/fgen_spi_regbank.sv
// fgen_spi_regbank: SPI mode-0 slave register bank for the function generator.
// The host writes 40-bit frames (command byte + 32 data bits) into shadow
// registers. A commit copies every shadow to the live outputs on one clk edge,
// so the generator never sees a half-applied reconfiguration.
// Optional feature macro: FGEN_REGBANK_READBACK_EN builds the MISO read path.
// Without it spi_miso is tied low and read frames complete with no effect.
//
// Handshake note: there is no valid/ready pair here. update_pulse and
// frame_err are single-cycle strobes that qualify the cycle in which the live
// registers have just loaded, or in which a frame was aborted.
module fgen_spi_regbank #(
    parameter logic [31:0] ID_VALUE    = 32'h5A47_1021,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [15:0] mode,
    output logic [15:0] amplitude,
    output logic [15:0] offset,
    output logic [31:0] conf_1_reg,
    output logic [31:0] conf_2_reg,
    output logic [31:0] conf_3_reg,
    output logic        update_pulse,
    output logic        frame_err
);

    // Elaboration-time sanity checks on the parameters.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (ID_VALUE == 32'h0) begin : g_bad_id
        $error("ID_VALUE must differ from the all-zero unmapped read value");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_cs_d;

    logic w_sck;
    logic w_cs_n;
    logic w_mosi;
    logic w_sck_rise;
    logic w_cs_fall;
    logic w_cs_rise;

    logic w_cmd_done;
    logic w_frame_done;
    logic w_abort;

    logic [5:0]  r_bit_cnt;
    logic [39:0] r_shift;
    logic        r_wr_pend;
    logic        r_commit_pend;
    logic        r_auto_commit;
    logic        r_update_pulse;
    logic        r_frame_err;

    logic [15:0] r_sh_mode;
    logic [15:0] r_sh_amp;
    logic [15:0] r_sh_off;
    logic [31:0] r_sh_c1;
    logic [31:0] r_sh_c2;
    logic [31:0] r_sh_c3;

    logic [15:0] r_mode;
    logic [15:0] r_amp;
    logic [15:0] r_off;
    logic [31:0] r_c1;
    logic [31:0] r_c2;
    logic [31:0] r_c3;

    logic        w_wr_en;
    logic [6:0]  w_wr_addr;
    logic [31:0] w_wr_data;

    // Synchronise the SPI pins into clk; cs_n idles high so reset cannot fake a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sck_d     <= w_sck;
            r_cs_d      <= w_cs_n;
        end
    end

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_d;
    assign w_cs_fall  = ~w_cs_n & r_cs_d;
    assign w_cs_rise  = w_cs_n & ~r_cs_d;

    // Frame FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame FSM next state and frame event strobes; cs_n rising always wins over an sck edge.
    always_comb begin
        w_state_nxt  = r_state;
        w_cmd_done   = 1'b0;
        w_frame_done = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = (r_bit_cnt != 6'd0);
                end else if (w_sck_rise && (r_bit_cnt == 6'd7)) begin
                    w_state_nxt = ST_DATA;
                    w_cmd_done  = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = 1'b1;
                end else if (w_sck_rise && (r_bit_cnt == 6'd39)) begin
                    w_state_nxt  = ST_DONE;
                    w_frame_done = 1'b1;
                end
            end
            ST_DONE: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Shift MOSI in on each rising sck while a frame is open; flag completion or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= 6'd0;
            r_shift     <= 40'd0;
            r_wr_pend   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_pend   <= w_frame_done;
            r_frame_err <= w_abort;
            if (w_state_nxt == ST_IDLE) begin
                r_bit_cnt <= 6'd0;
            end else if (((r_state == ST_CMD) || (r_state == ST_DATA)) && w_sck_rise) begin
                r_bit_cnt <= r_bit_cnt + 6'd1;
                r_shift   <= {r_shift[38:0], w_mosi};
            end
        end
    end

    assign w_wr_en   = r_wr_pend & ~r_shift[39];
    assign w_wr_addr = r_shift[38:32];
    assign w_wr_data = r_shift[31:0];

    // Shadow and CTRL writes one cycle after the frame completes; a commit is scheduled for the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_mode     <= 16'd0;
            r_sh_amp      <= 16'd0;
            r_sh_off      <= 16'd0;
            r_sh_c1       <= 32'd0;
            r_sh_c2       <= 32'd0;
            r_sh_c3       <= 32'd0;
            r_auto_commit <= 1'b0;
            r_commit_pend <= 1'b0;
        end else begin
            r_commit_pend <= 1'b0;
            if (w_wr_en) begin
                case (w_wr_addr)
                    7'd0: begin r_sh_mode <= w_wr_data[15:0]; r_commit_pend <= r_auto_commit; end
                    7'd1: begin r_sh_amp  <= w_wr_data[15:0]; r_commit_pend <= r_auto_commit; end
                    7'd2: begin r_sh_off  <= w_wr_data[15:0]; r_commit_pend <= r_auto_commit; end
                    7'd3: begin r_sh_c1   <= w_wr_data;       r_commit_pend <= r_auto_commit; end
                    7'd4: begin r_sh_c2   <= w_wr_data;       r_commit_pend <= r_auto_commit; end
                    7'd5: begin r_sh_c3   <= w_wr_data;       r_commit_pend <= r_auto_commit; end
                    7'd6: begin
                        r_auto_commit <= w_wr_data[1];
                        r_commit_pend <= w_wr_data[0];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Commit: every live register loads from its shadow on the same edge, flagged by update_pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode         <= 16'd0;
            r_amp          <= 16'd0;
            r_off          <= 16'd0;
            r_c1           <= 32'd0;
            r_c2           <= 32'd0;
            r_c3           <= 32'd0;
            r_update_pulse <= 1'b0;
        end else begin
            r_update_pulse <= r_commit_pend;
            if (r_commit_pend) begin
                r_mode <= r_sh_mode;
                r_amp  <= r_sh_amp;
                r_off  <= r_sh_off;
                r_c1   <= r_sh_c1;
                r_c2   <= r_sh_c2;
                r_c3   <= r_sh_c3;
            end
        end
    end

`ifdef FGEN_REGBANK_READBACK_EN
    logic        w_sck_fall;
    logic [7:0]  w_cmd_byte;
    logic [31:0] w_rd_mux;
    logic [31:0] r_rd_data;
    logic        r_rd_active;
    logic        r_miso;

    assign w_sck_fall = ~w_sck & r_sck_d;
    // The 8th command bit is still on the synchronised MOSI when the 8th rising edge is seen.
    assign w_cmd_byte = {r_shift[6:0], w_mosi};

    // Read mux over the shadows; 16-bit registers are zero-extended, unmapped addresses read 0.
    always_comb begin
        w_rd_mux = 32'd0;
        case (w_cmd_byte[6:0])
            7'd0:    w_rd_mux = {16'd0, r_sh_mode};
            7'd1:    w_rd_mux = {16'd0, r_sh_amp};
            7'd2:    w_rd_mux = {16'd0, r_sh_off};
            7'd3:    w_rd_mux = r_sh_c1;
            7'd4:    w_rd_mux = r_sh_c2;
            7'd5:    w_rd_mux = r_sh_c3;
            7'd6:    w_rd_mux = {30'd0, r_auto_commit, 1'b0};
            7'd7:    w_rd_mux = ID_VALUE;
            default: w_rd_mux = 32'd0;
        endcase
    end

    // Snapshot at the end of the command byte, then shift one bit out per falling sck in DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data   <= 32'd0;
            r_rd_active <= 1'b0;
            r_miso      <= 1'b0;
        end else if (w_cmd_done) begin
            r_rd_active <= w_cmd_byte[7];
            r_rd_data   <= w_rd_mux;
            r_miso      <= 1'b0;
        end else if ((r_state == ST_DATA) && (w_state_nxt == ST_DATA)) begin
            if (w_sck_fall && r_rd_active) begin
                r_miso    <= r_rd_data[31];
                r_rd_data <= {r_rd_data[30:0], 1'b0};
            end
        end else begin
            r_rd_active <= 1'b0;
            r_miso      <= 1'b0;
        end
    end

    assign spi_miso = r_miso;
`else
    assign spi_miso = 1'b0;
`endif

    assign mode         = r_mode;
    assign amplitude    = r_amp;
    assign offset       = r_off;
    assign conf_1_reg   = r_c1;
    assign conf_2_reg   = r_c2;
    assign conf_3_reg   = r_c3;
    assign update_pulse = r_update_pulse;
    assign frame_err    = r_frame_err;

endmodule
